// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: keyboard scancodes,
// joystick bit positions and the coin pulse state type.
package arcade_input_pkg;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLD
  } coin_state_t;

  // Direction bit positions, shared by joystick words and key-state vectors
  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  // Keys are matched as {extended, scancode}
  localparam logic [8:0] KEY_P1_UP        = 9'h175;
  localparam logic [8:0] KEY_P1_DOWN      = 9'h172;
  localparam logic [8:0] KEY_P1_LEFT      = 9'h16B;
  localparam logic [8:0] KEY_P1_RIGHT     = 9'h174;
  localparam logic [8:0] KEY_P1_B0        = 9'h029;
  localparam logic [8:0] KEY_P1_B1        = 9'h014;
  localparam logic [8:0] KEY_P1_B1_EXT    = 9'h114;
  localparam logic [8:0] KEY_P1_B2        = 9'h011;
  localparam logic [8:0] KEY_P1_B2_EXT    = 9'h111;
  localparam logic [8:0] KEY_P1_B3        = 9'h012;
  localparam logic [8:0] KEY_P1_START     = 9'h016;
  localparam logic [8:0] KEY_P1_START_ALT = 9'h005;
  localparam logic [8:0] KEY_P1_COIN      = 9'h02E;

  localparam logic [8:0] KEY_P2_UP        = 9'h02D;
  localparam logic [8:0] KEY_P2_DOWN      = 9'h02B;
  localparam logic [8:0] KEY_P2_LEFT      = 9'h023;
  localparam logic [8:0] KEY_P2_RIGHT     = 9'h034;
  localparam logic [8:0] KEY_P2_B0        = 9'h01C;
  localparam logic [8:0] KEY_P2_B1        = 9'h01B;
  localparam logic [8:0] KEY_P2_B2        = 9'h015;
  localparam logic [8:0] KEY_P2_B3        = 9'h01D;
  localparam logic [8:0] KEY_P2_START     = 9'h01E;
  localparam logic [8:0] KEY_P2_START_ALT = 9'h006;
  localparam logic [8:0] KEY_P2_COIN      = 9'h036;

  function automatic int joy_btn_idx(input int k);
    return 4 + k;
  endfunction

  function automatic int joy_start_idx(input int num_buttons);
    return 4 + num_buttons;
  endfunction

  function automatic int joy_coin_idx(input int num_buttons);
    return 5 + num_buttons;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Turns a raw coin level into one fixed-length pulse per insertion;
// a coin held down afterwards is parked in HOLD until released.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES = 1800000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_raw,
  output logic coin
);

  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COIN_CYCLES - 1);

  coin_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_q;

  // State, pulse counter and previous raw level for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= coin_raw;
    end
  end

  // Next state: edges seen while pulsing are deliberately ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COIN_IDLE: begin
        if (coin_raw && !raw_q) begin
          state_d = COIN_PULSE;
          cnt_d   = '0;
        end
      end
      COIN_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = coin_raw ? COIN_HOLD : COIN_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COIN_HOLD: begin
        if (!coin_raw) state_d = COIN_IDLE;
      end
      default: begin
        state_d = COIN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoded straight from the state flops so reset kills the pulse at once
  assign coin = (state_q == COIN_PULSE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard keys and joystick words into per-player arcade
// controls with optional rotation, autofire and coin pulse shaping.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 2,
  parameter int COIN_CYCLES = 1800000,
  parameter int AF_HALF     = 600000
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic [10:0]                        ps2_key,
  input  logic [15:0]                        joystick_0,
  input  logic [15:0]                        joystick_1,
  input  logic                               rotate,
  input  logic [NUM_BUTTONS-1:0]             af_en,
  input  logic                               kb_clear,
  output logic [NUM_PLAYERS-1:0]             up,
  output logic [NUM_PLAYERS-1:0]             down,
  output logic [NUM_PLAYERS-1:0]             left,
  output logic [NUM_PLAYERS-1:0]             right,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn,
  output logic [NUM_PLAYERS-1:0]             start,
  output logic [NUM_PLAYERS-1:0]             coin
);

  localparam int AW = $clog2(AF_HALF + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);

  logic       toggle_q, primed_q, kb_event;
  logic [8:0] key_code;
  logic       key_pressed;

  // Key states are kept for the full two-player, four-button keymap
  logic [1:0][3:0]  kb_dir, kb_btn;
  logic [1:0]       kb_start, kb_coin;
  logic [1:0][15:0] joy_all;

  logic [NUM_PLAYERS-1:0][3:0]             raw_dir;
  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] raw_btn;
  logic [NUM_PLAYERS-1:0]                  raw_start, raw_coin;
  logic [NUM_PLAYERS-1:0]                  af_active, af_phase;
  logic [NUM_PLAYERS-1:0][AW-1:0]          af_cnt;
  logic                                    unused_bits;

  assign joy_all     = {joystick_1, joystick_0};
  assign key_code    = ps2_key[8:0];
  assign key_pressed = ps2_key[9];
  assign kb_event    = primed_q && (ps2_key[10] != toggle_q);
  assign unused_bits = ^{joy_all, kb_dir, kb_btn, kb_start, kb_coin};

  // Track the PS/2 toggle; the first cycle after reset only samples it
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      primed_q <= 1'b1;
    end
  end

  // Keyboard key states; a clear request beats a same-cycle key event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      kb_dir   <= '0;
      kb_btn   <= '0;
      kb_start <= '0;
      kb_coin  <= '0;
    end else if (kb_clear) begin
      kb_dir   <= '0;
      kb_btn   <= '0;
      kb_start <= '0;
      kb_coin  <= '0;
    end else if (kb_event) begin
      case (key_code)
        KEY_P1_UP:                        kb_dir[0][DIR_U] <= key_pressed;
        KEY_P1_DOWN:                      kb_dir[0][DIR_D] <= key_pressed;
        KEY_P1_LEFT:                      kb_dir[0][DIR_L] <= key_pressed;
        KEY_P1_RIGHT:                     kb_dir[0][DIR_R] <= key_pressed;
        KEY_P1_B0:                        kb_btn[0][0]     <= key_pressed;
        KEY_P1_B1, KEY_P1_B1_EXT:         kb_btn[0][1]     <= key_pressed;
        KEY_P1_B2, KEY_P1_B2_EXT:         kb_btn[0][2]     <= key_pressed;
        KEY_P1_B3:                        kb_btn[0][3]     <= key_pressed;
        KEY_P1_START, KEY_P1_START_ALT:   kb_start[0]      <= key_pressed;
        KEY_P1_COIN:                      kb_coin[0]       <= key_pressed;
        KEY_P2_UP:                        kb_dir[1][DIR_U] <= key_pressed;
        KEY_P2_DOWN:                      kb_dir[1][DIR_D] <= key_pressed;
        KEY_P2_LEFT:                      kb_dir[1][DIR_L] <= key_pressed;
        KEY_P2_RIGHT:                     kb_dir[1][DIR_R] <= key_pressed;
        KEY_P2_B0:                        kb_btn[1][0]     <= key_pressed;
        KEY_P2_B1:                        kb_btn[1][1]     <= key_pressed;
        KEY_P2_B2:                        kb_btn[1][2]     <= key_pressed;
        KEY_P2_B3:                        kb_btn[1][3]     <= key_pressed;
        KEY_P2_START, KEY_P2_START_ALT:   kb_start[1]      <= key_pressed;
        KEY_P2_COIN:                      kb_coin[1]       <= key_pressed;
        default: ;
      endcase
    end
  end

  // Raw controls: keyboard OR the player's own joystick word
  always_comb begin
    raw_dir   = '0;
    raw_btn   = '0;
    raw_start = '0;
    raw_coin  = '0;
    af_active = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw_dir[p] = kb_dir[p] | joy_all[p][3:0];
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        raw_btn[p][k] = kb_btn[p][k] | joy_all[p][joy_btn_idx(k)];
      end
      raw_start[p] = kb_start[p] | joy_all[p][joy_start_idx(NUM_BUTTONS)];
      raw_coin[p]  = kb_coin[p]  | joy_all[p][joy_coin_idx(NUM_BUTTONS)];
      af_active[p] = |(raw_btn[p] & af_en);
    end
  end

  // Per-player autofire timebase; phase 0 is the high half of the cycle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!af_active[p]) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= 1'b0;
        end else if (af_cnt[p] == AF_LAST) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= ~af_phase[p];
        end else begin
          af_cnt[p] <= af_cnt[p] + 1'b1;
        end
      end
    end
  end

  // Registered outputs with rotation and autofire gating applied
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up    <= '0;
      down  <= '0;
      left  <= '0;
      right <= '0;
      btn   <= '0;
      start <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        up[p]    <= rotate ? raw_dir[p][DIR_L] : raw_dir[p][DIR_U];
        down[p]  <= rotate ? raw_dir[p][DIR_R] : raw_dir[p][DIR_D];
        left[p]  <= rotate ? raw_dir[p][DIR_D] : raw_dir[p][DIR_L];
        right[p] <= rotate ? raw_dir[p][DIR_U] : raw_dir[p][DIR_R];
        for (int k = 0; k < NUM_BUTTONS; k++) begin
          btn[p*NUM_BUTTONS+k] <= raw_btn[p][k] & ~(af_en[k] & af_phase[p]);
        end
        start[p] <= raw_start[p];
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    coin_pulser #(
      .COIN_CYCLES(COIN_CYCLES)
    ) u_coin_pulser (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .coin_raw(raw_coin[p]),
      .coin    (coin[p])
    );
  end

endmodule
